// File: rtl/dma_rd_queue_sel_pkg.sv
// ============================================================================
// Module      : dma_rd_queue_sel_pkg
// Description : Shared types and helpers for the DMA read-queue selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_rd_queue_sel_pkg;

    // Queue index width, shared with dma_engine_ctrl
    localparam int QIDX_W = 4;

    typedef enum logic [1:0] {
        DQS_Search  = 2'h0,
        DQS_Valid   = 2'h1,
        DQS_Holdoff = 2'h2
    } dqs_state_e;

    function automatic logic [QIDX_W-1:0] next_qidx(input logic [QIDX_W-1:0] idx,
                                                    input int               num_q);
        if (int'(idx) == num_q - 1) begin
            return '0;
        end
        return idx + QIDX_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_rd_queue_sel_rr_prio_enc.sv
// ============================================================================
// Module      : rr_prio_enc
// Description : Round-robin priority encoder: first request at or above ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_prio_enc
    import dma_rd_queue_sel_pkg::*;
#(
    parameter int NUM_Q = 16
) (
    input  logic [NUM_Q-1:0]  req_i,
    input  logic [QIDX_W-1:0] ptr_i,
    output logic              found_o,
    output logic [QIDX_W-1:0] idx_o
);

    logic [QIDX_W:0]   w_sum;
    logic [QIDX_W-1:0] w_cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_sum   = '0;
        w_cand  = '0;
        // Scan from the farthest candidate back so the nearest one overwrites
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr_i} + (QIDX_W+1)'(k);
            if (w_sum >= (QIDX_W+1)'(NUM_Q)) begin
                w_sum = w_sum - (QIDX_W+1)'(NUM_Q);
            end
            w_cand = w_sum[QIDX_W-1:0];
            if (req_i[w_cand]) begin
                found_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_rd_queue_sel.sv
// ============================================================================
// Module      : dma_rd_queue_sel
// Description : Round-robin pick of the next CNET queue for the DMA reader,
//               with a per-queue hold-off after each accept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_rd_queue_sel
    import dma_rd_queue_sel_pkg::*;
#(
    parameter int NUM_Q          = 16,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int HOLDOFF_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnet_reprog,
    input  logic [NUM_Q-1:0]  dma_pkt_avail,
    input  logic              dma_rd_request,
    output logic [QIDX_W-1:0] dma_rd_request_q,
    output logic              dma_rd_request_q_vld,
    output logic              holdoff_active
);

    dqs_state_e           state_q;
    logic [NUM_Q-1:0]     avail_q;
    logic [QIDX_W-1:0]    rr_ptr_q;
    logic [QIDX_W-1:0]    last_q_q;
    logic [HOLDOFF_W-1:0] hold_cnt_q;

    logic [NUM_Q-1:0]     w_mask;
    logic [NUM_Q-1:0]     w_elig;
    logic                 w_found;
    logic [QIDX_W-1:0]    w_pick;
    logic                 w_ho_vld_nxt;

    // The served queue's avail bit may still be stale during hold-off
    assign w_mask = (state_q == DQS_Holdoff) ? (NUM_Q'(1) << last_q_q) : '0;
    assign w_elig = avail_q & ~w_mask;

    rr_prio_enc #(
        .NUM_Q   (NUM_Q)
    ) u_rr_prio_enc (
        .req_i   (w_elig),
        .ptr_i   (rr_ptr_q),
        .found_o (w_found),
        .idx_o   (w_pick)
    );

    assign w_ho_vld_nxt = dma_rd_request_q_vld ? avail_q[dma_rd_request_q] : w_found;

    always_ff @(posedge clk) begin
        if (reset || cnet_reprog) begin
            state_q              <= DQS_Search;
            avail_q              <= '0;
            rr_ptr_q             <= '0;
            last_q_q             <= '0;
            hold_cnt_q           <= '0;
            dma_rd_request_q     <= '0;
            dma_rd_request_q_vld <= 1'b0;
            holdoff_active       <= 1'b0;
        end else begin
            avail_q <= dma_pkt_avail;
            case (state_q)
                DQS_Search: begin
                    if (w_found) begin
                        dma_rd_request_q     <= w_pick;
                        dma_rd_request_q_vld <= 1'b1;
                        state_q              <= DQS_Valid;
                    end
                end
                DQS_Valid, DQS_Holdoff: begin
                    if (dma_rd_request_q_vld && dma_rd_request) begin
                        dma_rd_request_q_vld <= 1'b0;
                        last_q_q             <= dma_rd_request_q;
                        rr_ptr_q             <= next_qidx(dma_rd_request_q, NUM_Q);
                        hold_cnt_q           <= HOLDOFF_W'(HOLDOFF_CYCLES);
                        holdoff_active       <= 1'b1;
                        state_q              <= DQS_Holdoff;
                    end else if (state_q == DQS_Valid) begin
                        if (!avail_q[dma_rd_request_q]) begin
                            dma_rd_request_q_vld <= 1'b0;
                            state_q              <= DQS_Search;
                        end
                    end else begin
                        if (!dma_rd_request_q_vld && w_found) begin
                            dma_rd_request_q     <= w_pick;
                            dma_rd_request_q_vld <= 1'b1;
                        end else if (dma_rd_request_q_vld && !avail_q[dma_rd_request_q]) begin
                            dma_rd_request_q_vld <= 1'b0;
                        end
                        if (hold_cnt_q == HOLDOFF_W'(1)) begin
                            hold_cnt_q     <= '0;
                            holdoff_active <= 1'b0;
                            state_q        <= w_ho_vld_nxt ? DQS_Valid : DQS_Search;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLDOFF_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= DQS_Search;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
